// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: ALU control codes, alu_op
// encodings and the execute FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_ERR  = 4'b1111;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } exec_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: {alu_op, funct3, funct7_5} to a 4-bit
// control code plus shift and illegal flags.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ctrl,
  output logic       is_shift,
  output logic       illegal
);

  logic r_type;
  logic [3:0] raw_ctrl;

  assign r_type = (alu_op == ALU_OP_RTYPE);

  always_comb begin
    raw_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALU_OP_MEM:    raw_ctrl = ALU_ADD;
      ALU_OP_BRANCH: raw_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  raw_ctrl = (r_type && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  raw_ctrl = ALU_SLL;
          3'b010:  raw_ctrl = ALU_SLT;
          3'b011:  raw_ctrl = ALU_SLTU;
          3'b100:  raw_ctrl = ALU_XOR;
          3'b101:  raw_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  raw_ctrl = ALU_OR;
          default: raw_ctrl = ALU_AND;
        endcase
        // I-type only has bit 30 meaning for shifts; elsewhere it is immediate
        if (r_type && funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101))
          illegal = 1'b1;
        if (!r_type && (funct3 == 3'b001) && funct7_5)
          illegal = 1'b1;
      end
    endcase
  end

  assign ctrl     = illegal ? ALU_ERR : raw_ctrl;
  assign is_shift = !illegal &&
                    ((raw_ctrl == ALU_SLL) || (raw_ctrl == ALU_SRL) || (raw_ctrl == ALU_SRA));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle ALU ops, iterative shifter
// (SHIFT_STEP bits per cycle), valid/ready on both sides, registered outputs.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  exec_state_t state_reg, state_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      op_reg, op_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            zero_reg, zero_next;
  logic            illegal_reg, illegal_next;
  logic            out_valid_reg, out_valid_next;

  logic [3:0]      dec_ctrl;
  logic            dec_is_shift;
  logic            dec_illegal;
  logic [XLEN-1:0] alu_res;
  logic [CW-1:0]   shamt;
  logic [CW-1:0]   first_step, first_cnt, run_step, run_cnt;
  logic [XLEN-1:0] first_acc, run_acc;

  alu_ctrl_decode u_decode (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .ctrl     (dec_ctrl),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [CW-1:0] amt,
                                               input logic [3:0] op);
    case (op)
      ALU_SLL: return v << amt;
      ALU_SRA: return $unsigned($signed(v) >>> amt);
      default: return v >> amt;
    endcase
  endfunction

  function automatic logic [CW-1:0] step_of(input logic [CW-1:0] remaining);
    return (remaining < STEP) ? remaining : STEP;
  endfunction

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_ADD:  alu_res = a + b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SUB:  alu_res = a - b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  alu_res = '0;
    endcase
  end

  // The accept edge already performs the first shift step, so a shift costs
  // ceil(shamt/SHIFT_STEP) edges in total (minimum one).
  assign shamt      = b[CW-1:0];
  assign first_step = step_of(shamt);
  assign first_acc  = shift_by(a, first_step, dec_ctrl);
  assign first_cnt  = shamt - first_step;
  assign run_step   = step_of(cnt_reg);
  assign run_acc    = shift_by(acc_reg, run_step, op_reg);
  assign run_cnt    = cnt_reg - run_step;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    result_next    = result_reg;
    zero_next      = zero_reg;
    illegal_next   = illegal_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            result_next    = '0;
            zero_next      = 1'b1;
            illegal_next   = 1'b1;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else if (!dec_is_shift) begin
            result_next    = alu_res;
            zero_next      = (alu_res == '0);
            illegal_next   = 1'b0;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else if (first_cnt == '0) begin
            result_next    = first_acc;
            zero_next      = (first_acc == '0);
            illegal_next   = 1'b0;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else begin
            acc_next   = first_acc;
            cnt_next   = first_cnt;
            op_next    = dec_ctrl;
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_next = run_acc;
        cnt_next = run_cnt;
        if (run_cnt == '0) begin
          result_next    = run_acc;
          zero_next      = (run_acc == '0);
          illegal_next   = 1'b0;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      op_reg        <= ALU_SLL;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      result_reg    <= result_next;
      zero_reg      <= zero_next;
      illegal_reg   <= illegal_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: two units (SHIFT_STEP 1 and 4) driven in lockstep,
// compared against an arithmetic reference model of the RV32I ALU rules.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] a, b;
  logic        out_ready;

  logic        in_ready1, out_valid1, zero1, illegal1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, zero4, illegal4;
  logic [31:0] result4;

  int compared   = 0;
  int mismatched = 0;
  int txn_no     = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .zero(zero1), .illegal(illegal1)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .zero(zero4), .illegal(illegal4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the instruction-set rules.
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic ill,
                       output int lat1, output int lat4);
    int sh;
    bit rt, shift_op;
    sh  = int'(y[4:0]);
    rt  = (op == 2'b10);
    ill = 1'b0;
    shift_op = 1'b0;
    if (op == 2'b00) res = x + y;
    else if (op == 2'b01) res = x - y;
    else begin
      ill = (rt && f7 && f3 != 3'd0 && f3 != 3'd5) || (!rt && f3 == 3'd1 && f7);
      case (f3)
        3'd0: res = (rt && f7) ? x - y : x + y;
        3'd1: res = x << sh;
        3'd2: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: res = (x < y) ? 32'd1 : 32'd0;
        3'd4: res = x ^ y;
        3'd5: res = f7 ? $unsigned($signed(x) >>> sh) : x >> sh;
        3'd6: res = x | y;
        default: res = x & y;
      endcase
      shift_op = (f3 == 3'd1 || f3 == 3'd5) && !ill;
      if (ill) res = 32'd0;
    end
    lat1 = shift_op ? ((sh < 1) ? 1 : sh) : 1;
    lat4 = shift_op ? (((sh + 3) / 4 < 1) ? 1 : (sh + 3) / 4) : 1;
  endtask

  task automatic scramble_inputs();
    alu_op = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
    a = $urandom; b = $urandom;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] x, input logic [31:0] y, input int stall);
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat1, exp_lat4, lat1, lat4, edges;
    string       t;
    model(op, f3, f7, x, y, exp_res, exp_ill, exp_lat1, exp_lat4);
    t = $sformatf("t%0d", txn_no);
    chk({t, "_inready_pre"}, {31'd0, in_ready1 & in_ready4}, 32'd1);
    alu_op = op; funct3 = f3; funct7_5 = f7; a = x; b = y; in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    edges = 1; lat1 = -1; lat4 = -1;
    while ((lat1 < 0 || lat4 < 0) && edges <= 64) begin
      if (lat1 < 0 && out_valid1) lat1 = edges;
      if (lat4 < 0 && out_valid4) lat4 = edges;
      if (lat1 < 0 || lat4 < 0) begin
        @(negedge clk);
        edges++;
      end
    end
    chk({t, "_lat1"}, 32'(lat1), 32'(exp_lat1));
    chk({t, "_lat4"}, 32'(lat4), 32'(exp_lat4));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      chk({t, "_stall_res"}, result1, exp_res);
      chk({t, "_stall_inready"}, {31'd0, in_ready1 | in_ready4}, 32'd0);
      chk({t, "_stall_valid"}, {31'd0, out_valid1 & out_valid4}, 32'd1);
    end
    chk({t, "_res1"}, result1, exp_res);
    chk({t, "_res4"}, result4, exp_res);
    chk({t, "_zero1"}, {31'd0, zero1}, {31'd0, exp_res == 32'd0});
    chk({t, "_zero4"}, {31'd0, zero4}, {31'd0, exp_res == 32'd0});
    chk({t, "_ill1"}, {31'd0, illegal1}, {31'd0, exp_ill});
    chk({t, "_ill4"}, {31'd0, illegal4}, {31'd0, exp_ill});
    $display("txn %0d op=%b f3=%0d f7=%0d a=%h b=%h res=%h/%h lat=%0d/%0d ill=%0d",
             txn_no, op, f3, f7, x, y, result1, result4, lat1, lat4, illegal1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({t, "_post_valid"}, {31'd0, out_valid1 | out_valid4}, 32'd0);
    chk({t, "_post_inready"}, {31'd0, in_ready1 & in_ready4}, 32'd1);
    txn_no++;
  endtask

  initial begin
    bit saw_valid;
    logic [1:0] r_op;
    logic [2:0] r_f3;
    logic       r_f7;
    logic [31:0] r_a, r_b;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct3 = '0; funct7_5 = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_inready", {31'd0, in_ready1 & in_ready4}, 32'd1);
    chk("reset_valid", {31'd0, out_valid1 | out_valid4}, 32'd0);
    chk("reset_result", result1 | result4, 32'd0);
    chk("reset_flags", {30'd0, zero1 | zero4, illegal1 | illegal4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a long SLL
    alu_op = 2'b10; funct3 = 3'd1; funct7_5 = 1'b0; a = 32'd1; b = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midshift_busy", {31'd0, in_ready1}, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_inready", {31'd0, in_ready1 & in_ready4}, 32'd1);
    chk("rst_release_valid", {31'd0, out_valid1 | out_valid4}, 32'd0);
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) saw_valid = 1'b1;
    end
    chk("rst_no_result", {31'd0, saw_valid}, 32'd0);

    // Directed cases
    do_txn(2'b10, 3'd0, 1'b1, 32'd5, 32'd7, 0);
    chk("sub_const", result1, 32'hFFFF_FFFE);
    do_txn(2'b10, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_txn(2'b10, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_txn(2'b10, 3'd5, 1'b1, 32'h8000_0000, 32'd31, 0);
    do_txn(2'b10, 3'd1, 1'b0, 32'h0000_1234, 32'd32, 0);
    do_txn(2'b10, 3'd1, 1'b0, 32'd1, 32'd33, 0);
    chk("sll_mask_const", result1, 32'd2);
    do_txn(2'b10, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_txn(2'b11, 3'd0, 1'b1, 32'd3, 32'd4, 0);
    do_txn(2'b11, 3'd1, 1'b1, 32'd3, 32'd4, 0);
    do_txn(2'b11, 3'd5, 1'b1, 32'h9000_0000, 32'd6, 0);
    do_txn(2'b01, 3'd2, 1'b1, 32'd42, 32'd42, 0);
    do_txn(2'b00, 3'd5, 1'b1, 32'hFFFF_FFFF, 32'd2, 0);
    do_txn(2'b10, 3'd5, 1'b0, 32'h8000_0001, 32'd7, 0);
    // Back-pressure with ignored requests during the stall
    do_txn(2'b10, 3'd6, 1'b0, 32'h0F00_0000, 32'h0000_00F0, 5);
    do_txn(2'b11, 3'd4, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 0);

    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom); r_f3 = 3'($urandom); r_f7 = 1'($urandom);
      r_a = $urandom; r_b = $urandom;
      if (n % 4 == 0) r_b = 32'($urandom_range(0, 40));
      do_txn(r_op, r_f3, r_f7, r_a, r_b, (n % 8 == 3) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
